// File: rtl/instr_fetch_unit_if.sv
// +--------------------------------------------------------------------------+
// | Module  : instr_fetch_unit_if                                            |
// | Brief   : Fetch bus (instruction memory + decode handshake) bundle.      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

interface instr_fetch_unit_if #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [10:0]        opcode;
    logic               instr_valid;
    logic               instr_ack;
    logic               branch;
    logic               uncond_branch;
    logic               zero;
    logic [PC_W-1:0]    branch_off;
    logic [PC_W-1:0]    pc;

    // master: the fetch unit; slave: memory and decode as seen by it
    modport master (
        output imem_req, imem_addr, instr, opcode, instr_valid, pc,
        input  imem_ready, imem_rdata, instr_ack, branch, uncond_branch, zero, branch_off
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, instr_valid, pc,
        output imem_ready, imem_rdata, instr_ack, branch, uncond_branch, zero, branch_off
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | Module  : instr_fetch_unit                                               |
// | Brief   : PC holder and variable-latency instruction fetch for decode.   |
// |           Define FETCH_PERF_CNT_EN to add instr_cnt / taken_cnt outputs. |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_fetch_unit #(
    parameter int              PC_W     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int              CNT_W    = 32
`endif
) (
    input  wire logic              CLK,
    input  wire logic              resetl,
    instr_fetch_unit_if.master     bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]       instr_cnt,
    output logic [CNT_W-1:0]       taken_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic [PC_W-1:0]    w_branch_tgt;

    // Top two offset bits fall off the shift; the add wraps modulo 2^PC_W.
    assign w_branch_tgt = r_pc + (bus.branch_off << 2);

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (bus.imem_ready) begin
                    w_instr_nxt = bus.imem_rdata;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (bus.instr_ack) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_REQ;
                    // Nested if/else keeps an unknown branch away from pc when B is taken.
                    if (bus.uncond_branch) begin
                        w_pc_nxt = w_branch_tgt;
                    end else if (bus.branch && bus.zero) begin
                        w_pc_nxt = w_branch_tgt;
                    end else begin
                        w_pc_nxt = r_pc + PC_W'(4);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.imem_req    = (r_state == S_REQ);
    assign bus.imem_addr   = r_pc;
    assign bus.pc          = r_pc;
    assign bus.instr       = r_instr;
    assign bus.opcode      = r_instr[31:21];
    assign bus.instr_valid = r_valid;

`ifdef FETCH_PERF_CNT_EN
    logic w_ack_fire;
    logic w_taken;

    assign w_ack_fire = (r_state == S_VALID) && bus.instr_ack;
    assign w_taken    = w_ack_fire && (bus.uncond_branch || (bus.branch && bus.zero));

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            instr_cnt <= '0;
            taken_cnt <= '0;
        end else begin
            if (w_ack_fire) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
            if (w_taken) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_instr_fetch_unit                                            |
// | Brief   : Directed stimulus with a queue-based scoreboard and monitor.   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch_unit;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } exp_t;

    logic CLK    = 1'b0;
    logic resetl = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    exp_t q[$];

    always #5 CLK = ~CLK;

    instr_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instr_cnt;
    logic [31:0] taken_cnt;
`endif

    instr_fetch_unit #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (64'h0)
`ifdef FETCH_PERF_CNT_EN
        ,
        .CNT_W    (32)
`endif
    ) dut (
        .CLK       (CLK),
        .resetl    (resetl),
        .bus       (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .instr_cnt (instr_cnt),
        .taken_cnt (taken_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: each rising instr_valid must match the oldest expected fetch.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (!resetl) begin
                prev = 1'b0;
            end else begin
                if (bus.instr_valid && !prev) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL mon_unexpected: got instr %h want none", bus.instr);
                    end else begin
                        e = q.pop_front();
                        chk("mon_pc", bus.pc, e.addr);
                        chk("mon_instr", {32'h0, bus.instr}, {32'h0, e.data});
                        chk("mon_opcode", {53'h0, bus.opcode}, {53'h0, e.data[31:21]});
                    end
                end
                prev = bus.instr_valid;
            end
        end
    end

    task automatic wait_req();
        int n;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("req_seen", {63'h0, bus.imem_req}, 64'h1);
    endtask

    task automatic do_fetch(input logic [63:0] addr, input logic [31:0] data, input int stall);
        exp_t e;
        wait_req();
        chk("imem_addr", bus.imem_addr, addr);
        e.addr = addr;
        e.data = data;
        q.push_back(e);
        bus.imem_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            bus.instr_ack = 1'b1;
            @(posedge CLK); #1;
            chk("stall_req", {63'h0, bus.imem_req}, 64'h1);
            chk("stall_addr", bus.imem_addr, addr);
            chk("stall_valid", {63'h0, bus.instr_valid}, 64'h0);
        end
        bus.instr_ack  = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = data;
        @(posedge CLK); #1;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        chk("latency_valid", {63'h0, bus.instr_valid}, 64'h1);
        chk("valid_req_low", {63'h0, bus.imem_req}, 64'h0);
    endtask

    task automatic do_ack(input logic ub, input logic br, input logic z, input logic [63:0] off);
        bus.uncond_branch = ub;
        bus.branch        = br;
        bus.zero          = z;
        bus.branch_off    = off;
        bus.instr_ack     = 1'b1;
        @(posedge CLK); #1;
        bus.instr_ack     = 1'b0;
        bus.uncond_branch = 1'b0;
        bus.branch        = 1'b0;
        bus.zero          = 1'b0;
        bus.branch_off    = 64'h0;
        chk("ack_valid_drop", {63'h0, bus.instr_valid}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.imem_ready    = 1'b0;
        bus.imem_rdata    = 32'h0;
        bus.instr_ack     = 1'b0;
        bus.branch        = 1'b0;
        bus.uncond_branch = 1'b0;
        bus.zero          = 1'b0;
        bus.branch_off    = 64'h0;

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pc", bus.pc, 64'h0);
        chk("rst_valid", {63'h0, bus.instr_valid}, 64'h0);
        chk("rst_req", {63'h0, bus.imem_req}, 64'h0);
        chk("rst_instr", {32'h0, bus.instr}, 64'h0);
        chk("rst_opcode", {53'h0, bus.opcode}, 64'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_instr_cnt", {32'h0, instr_cnt}, 64'h0);
        chk("rst_taken_cnt", {32'h0, taken_cnt}, 64'h0);
`endif
        resetl = 1'b1;

        // Sequential fetches from RESET_PC
        do_fetch(64'h0,  32'h8B02_0020, 0); do_ack(1'b0, 1'b0, 1'b0, 64'h0);
        do_fetch(64'h4,  32'hF840_0041, 0); do_ack(1'b0, 1'b0, 1'b0, 64'h0);
        do_fetch(64'h8,  32'hB400_0062, 0); do_ack(1'b0, 1'b0, 1'b0, 64'h0);
        do_fetch(64'hC,  32'h9100_0421, 0); do_ack(1'b0, 1'b0, 1'b0, 64'h0);
        // CBZ taken / not taken
        do_fetch(64'h10, 32'hB400_0063, 0); do_ack(1'b0, 1'b1, 1'b1, 64'd3);
        do_fetch(64'h1C, 32'hCB02_0020, 0); do_ack(1'b0, 1'b1, 1'b0, 64'd3);
        do_fetch(64'h20, 32'h17FF_FFFC, 0); do_ack(1'b1, 1'b0, 1'b0, -64'sd4);
        do_fetch(64'h10, 32'hB400_0064, 0); do_ack(1'b0, 1'b1, 1'b0, 64'd3);
        // B with unknown branch input
        do_fetch(64'h14, 32'h1400_000B, 0); do_ack(1'b1, 1'b0, 1'b0, 64'd11);
        do_fetch(64'h40, 32'h17FF_FFFC, 0); do_ack(1'b1, 1'bx, 1'b0, -64'sd4);
        chk("b_pc_no_x", bus.pc, 64'h30);
        // Stalled memory, then decode holding off ack
        do_fetch(64'h30, 32'hAA01_03E0, 5);
        repeat (2) begin
            @(posedge CLK); #1;
            chk("hold_valid", {63'h0, bus.instr_valid}, 64'h1);
            chk("hold_pc", bus.pc, 64'h30);
        end
        do_ack(1'b1, 1'b0, 1'b0, -64'sd13);
        // PC wrap and dropped offset bits
        do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'hD503_201F, 0); do_ack(1'b0, 1'b0, 1'b0, 64'h0);
        do_fetch(64'h0, 32'h8B1F_03E0, 0); do_ack(1'b1, 1'b0, 1'b0, 64'hC000_0000_0000_0001);

        // Reset while a fetch is outstanding
        wait_req();
        chk("pre_rst_addr", bus.imem_addr, 64'h4);
        @(posedge CLK); #1;
        resetl = 1'b0;
        #1;
        chk("arst_pc", bus.pc, 64'h0);
        chk("arst_req", {63'h0, bus.imem_req}, 64'h0);
        chk("arst_valid", {63'h0, bus.instr_valid}, 64'h0);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        @(posedge CLK); #1;
        chk("arst_stale_valid", {63'h0, bus.instr_valid}, 64'h0);
        chk("arst_stale_instr", {32'h0, bus.instr}, 64'h0);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'h0;
        resetl = 1'b1;

        // Three retirements, one redirect
        do_fetch(64'h0, 32'hF940_0000, 0); do_ack(1'b0, 1'b0, 1'b0, 64'h0);
        do_fetch(64'h4, 32'hB400_0042, 0); do_ack(1'b0, 1'b1, 1'b1, 64'd2);
        do_fetch(64'hC, 32'hD65F_03C0, 0); do_ack(1'b0, 1'b0, 1'b0, 64'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("instr_cnt", {32'h0, instr_cnt}, 64'd3);
        chk("taken_cnt", {32'h0, taken_cnt}, 64'd1);
`endif
        do_fetch(64'h10, 32'h9100_0842, 0);

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("scoreboard_drained", 64'(q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
